// File: rtl/round_ctrl_if.sv
// Signal bundle between the round sequencer and the buttons, tick source,
// stopwatch and display datapath.
interface round_ctrl_if;
    logic       tick_1hz;
    logic       btn_start;
    logic       btn_pause;
    logic       hit;
    logic [3:0] sw_small;
    logic [2:0] sw_big;
    logic       sw_rst;
    logic       sw_pause;
    logic       play_en;
    logic [1:0] cd_val;
    logic [2:0] state;
    logic [3:0] score_lo;
    logic [3:0] score_hi;
    logic       round_done;

    modport slave (
        input  tick_1hz, btn_start, btn_pause, hit, sw_small, sw_big,
        output sw_rst, sw_pause, play_en, cd_val, state, score_lo, score_hi, round_done
    );

    modport master (
        output tick_1hz, btn_start, btn_pause, hit, sw_small, sw_big,
        input  sw_rst, sw_pause, play_en, cd_val, state, score_lo, score_hi, round_done
    );
endinterface

// File: rtl/round_ctrl.sv
// Whack-a-mole round sequencer: start countdown, play/pause gating of the
// stopwatch, round-end detection and a saturating two-digit BCD score.
module round_ctrl #(
    parameter int ROUND_BIG   = 3,
    parameter int ROUND_SMALL = 0,
    parameter int CD_START    = 3
) (
    input  logic        clk,
    input  logic        rst,
    round_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CD     = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_PAUSED = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

    logic [2:0] state_q, state_d;
    logic [1:0] cd_q, cd_d;
    logic [3:0] lo_q, lo_d, hi_q, hi_d;
    logic       sw_rst_q, sw_rst_d;
    logic       sw_pause_q, sw_pause_d;
    logic       play_en_q, play_en_d;
    logic       done_q, done_d;
    logic       limit;

    assign limit = (bus.sw_big > 3'(ROUND_BIG)) ||
                   ((bus.sw_big == 3'(ROUND_BIG)) && (bus.sw_small >= 4'(ROUND_SMALL)));

    // State register plus all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cd_q       <= 2'd0;
            lo_q       <= 4'd0;
            hi_q       <= 4'd0;
            sw_rst_q   <= 1'b1;
            sw_pause_q <= 1'b1;
            play_en_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cd_q       <= cd_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            sw_rst_q   <= sw_rst_d;
            sw_pause_q <= sw_pause_d;
            play_en_q  <= play_en_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; limit beats pause, start beats pause.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.btn_start) state_d = S_CD;
            S_CD:     if (bus.tick_1hz && cd_q == 2'd1) state_d = S_PLAY;
            S_PLAY: begin
                if (limit)              state_d = S_OVER;
                else if (bus.btn_pause) state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (bus.btn_start)      state_d = S_IDLE;
                else if (bus.btn_pause) state_d = S_PLAY;
            end
            S_OVER:   if (bus.btn_start) state_d = S_CD;
            default:  state_d = S_IDLE;
        endcase
    end

    // Countdown digit and score datapath.
    always_comb begin
        cd_d = cd_q;
        lo_d = lo_q;
        hi_d = hi_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.btn_start) begin
                    cd_d = 2'(CD_START);
                    lo_d = 4'd0;
                    hi_d = 4'd0;
                end
            end
            S_CD: if (bus.tick_1hz) cd_d = cd_q - 2'd1;
            S_PLAY: begin
                if (bus.hit && !(hi_q == 4'd9 && lo_q == 4'd9)) begin
                    if (lo_q == 4'd9) begin
                        lo_d = 4'd0;
                        hi_d = hi_q + 4'd1;
                    end else begin
                        lo_d = lo_q + 4'd1;
                    end
                end
            end
            S_PAUSED: ;
            default: begin
                // Illegal code: behave like a reset.
                cd_d = 2'd0;
                lo_d = 4'd0;
                hi_d = 4'd0;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they register alongside it.
    always_comb begin
        sw_rst_d   = (state_d == S_IDLE) || (state_d == S_CD);
        sw_pause_d = (state_d != S_PLAY);
        play_en_d  = (state_d == S_PLAY);
        done_d     = (state_q == S_PLAY) && (state_d == S_OVER);
    end

    assign bus.state      = state_q;
    assign bus.cd_val     = cd_q;
    assign bus.score_lo   = lo_q;
    assign bus.score_hi   = hi_q;
    assign bus.sw_rst     = sw_rst_q;
    assign bus.sw_pause   = sw_pause_q;
    assign bus.play_en    = play_en_q;
    assign bus.round_done = done_q;
endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with default parameters (3/0, countdown 3).
module tb_round_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    round_ctrl_if bus();

    round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        bus.tick_1hz = 1'b1;
        cyc();
        bus.tick_1hz = 1'b0;
    endtask

    task automatic pulse_start();
        bus.btn_start = 1'b1;
        cyc();
        bus.btn_start = 1'b0;
    endtask

    task automatic pulse_pause();
        bus.btn_pause = 1'b1;
        cyc();
        bus.btn_pause = 1'b0;
    endtask

    task automatic pulse_hit();
        bus.hit = 1'b1;
        cyc();
        bus.hit = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] snap;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        checks++;
        if ({bus.state, bus.sw_rst, bus.sw_pause, bus.play_en, bus.cd_val, bus.round_done} !== {3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: got st=%0d rst=%b pau=%b en=%b cd=%0d done=%b, want st=0 rst=1 pau=1 en=0 cd=0 done=0",
                     bus.state, bus.sw_rst, bus.sw_pause, bus.play_en, bus.cd_val, bus.round_done);
        end
        checks++;
        if ({bus.score_hi, bus.score_lo} !== 8'h00) begin
            errors++;
            $display("FAIL reset_score: got %h%h want 00", bus.score_hi, bus.score_lo);
        end
        snap = {bus.state, bus.sw_rst, bus.sw_pause, bus.play_en, bus.cd_val, bus.score_hi, bus.score_lo};
        for (int i = 0; i < 10; i++) begin
            pulse_tick();
            cyc();
        end
        checks++;
        if ({bus.state, bus.sw_rst, bus.sw_pause, bus.play_en, bus.cd_val, bus.score_hi, bus.score_lo} !== {3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00}) begin
            errors++;
            $display("FAIL idle_ticks: got %h (was %h) want %h",
                     {bus.state, bus.sw_rst, bus.sw_pause, bus.play_en, bus.cd_val, bus.score_hi, bus.score_lo}, snap,
                     {3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00});
        end
    endtask

    // Start press then three ticks, checking the countdown digit after each.
    task automatic test_start();
        logic [1:0] exp_cd [4];
        exp_cd = '{2'd3, 2'd2, 2'd1, 2'd0};
        pulse_start();
        checks++;
        if ({bus.state, bus.sw_rst, bus.sw_pause} !== {3'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL start_cd_state: got st=%0d rst=%b pau=%b want st=1 rst=1 pau=1", bus.state, bus.sw_rst, bus.sw_pause);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                cyc();
                pulse_tick();
            end
            checks++;
            if (bus.cd_val !== exp_cd[i]) begin
                errors++;
                $display("FAIL countdown_%0d: got cd=%0d want %0d", i, bus.cd_val, exp_cd[i]);
            end
        end
        checks++;
        if ({bus.state, bus.sw_rst, bus.sw_pause, bus.play_en} !== {3'd2, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL enter_play: got st=%0d rst=%b pau=%b en=%b want st=2 rst=0 pau=0 en=1",
                     bus.state, bus.sw_rst, bus.sw_pause, bus.play_en);
        end
    endtask

    task automatic test_pause_abandon();
        pulse_pause();
        checks++;
        if ({bus.state, bus.sw_pause, bus.play_en} !== {3'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL pause: got st=%0d pau=%b en=%b want st=3 pau=1 en=0", bus.state, bus.sw_pause, bus.play_en);
        end
        pulse_hit();
        pulse_hit();
        checks++;
        if ({bus.score_hi, bus.score_lo} !== 8'h00) begin
            errors++;
            $display("FAIL paused_hit: got %h%h want 00", bus.score_hi, bus.score_lo);
        end
        pulse_pause();
        checks++;
        if ({bus.state, bus.sw_pause, bus.play_en} !== {3'd2, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL resume: got st=%0d pau=%b en=%b want st=2 pau=0 en=1", bus.state, bus.sw_pause, bus.play_en);
        end
        pulse_pause();
        bus.btn_pause = 1'b1;
        bus.btn_start = 1'b1;
        cyc();
        bus.btn_pause = 1'b0;
        bus.btn_start = 1'b0;
        checks++;
        if ({bus.state, bus.sw_rst, bus.sw_pause, bus.play_en} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abandon: got st=%0d rst=%b pau=%b en=%b want st=0 rst=1 pau=1 en=0",
                     bus.state, bus.sw_rst, bus.sw_pause, bus.play_en);
        end
    endtask

    task automatic go_play();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            cyc();
            pulse_tick();
        end
    endtask

    task automatic test_round_end();
        go_play();
        bus.sw_big = 3'd2;
        bus.sw_small = 4'd9;
        cyc();
        cyc();
        checks++;
        if ({bus.state, bus.round_done} !== {3'd2, 1'b0}) begin
            errors++;
            $display("FAIL below_limit: got st=%0d done=%b want st=2 done=0", bus.state, bus.round_done);
        end
        bus.sw_big = 3'd3;
        bus.sw_small = 4'd0;
        bus.btn_pause = 1'b1;
        bus.hit = 1'b1;
        cyc();
        bus.btn_pause = 1'b0;
        bus.hit = 1'b0;
        checks++;
        if ({bus.state, bus.round_done, bus.sw_pause, bus.play_en} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL limit_over: got st=%0d done=%b pau=%b en=%b want st=4 done=1 pau=1 en=0",
                     bus.state, bus.round_done, bus.sw_pause, bus.play_en);
        end
        checks++;
        if ({bus.score_hi, bus.score_lo} !== 8'h01) begin
            errors++;
            $display("FAIL limit_hit: got %h%h want 01", bus.score_hi, bus.score_lo);
        end
        cyc();
        checks++;
        if ({bus.state, bus.round_done} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL done_width: got st=%0d done=%b want st=4 done=0", bus.state, bus.round_done);
        end
    endtask

    // Restart from OVER, then 105 back-to-back hits.
    task automatic test_score_sat();
        pulse_start();
        checks++;
        if ({bus.state, bus.cd_val, bus.score_hi, bus.score_lo} !== {3'd1, 2'd3, 8'h00}) begin
            errors++;
            $display("FAIL restart: got st=%0d cd=%0d score=%h%h want st=1 cd=3 score=00",
                     bus.state, bus.cd_val, bus.score_hi, bus.score_lo);
        end
        bus.sw_big = 3'd0;
        bus.sw_small = 4'd0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            pulse_tick();
        end
        bus.hit = 1'b1;
        for (int i = 1; i <= 105; i++) begin
            cyc();
            if (i == 9) begin
                checks++;
                if ({bus.score_hi, bus.score_lo} !== 8'h09) begin
                    errors++;
                    $display("FAIL score_09: got %h%h want 09", bus.score_hi, bus.score_lo);
                end
            end
            if (i == 10) begin
                checks++;
                if ({bus.score_hi, bus.score_lo} !== 8'h10) begin
                    errors++;
                    $display("FAIL score_carry: got %h%h want 10", bus.score_hi, bus.score_lo);
                end
            end
            if (i == 99) begin
                checks++;
                if ({bus.score_hi, bus.score_lo} !== 8'h99) begin
                    errors++;
                    $display("FAIL score_99: got %h%h want 99", bus.score_hi, bus.score_lo);
                end
            end
        end
        bus.hit = 1'b0;
        checks++;
        if ({bus.score_hi, bus.score_lo} !== 8'h99) begin
            errors++;
            $display("FAIL score_sat: got %h%h want 99", bus.score_hi, bus.score_lo);
        end
        bus.sw_big = 3'd3;
        cyc();
        bus.sw_big = 3'd0;
        pulse_start();
        checks++;
        if ({bus.state, bus.cd_val, bus.score_hi, bus.score_lo} !== {3'd1, 2'd3, 8'h00}) begin
            errors++;
            $display("FAIL restart_over: got st=%0d cd=%0d score=%h%h want st=1 cd=3 score=00",
                     bus.state, bus.cd_val, bus.score_hi, bus.score_lo);
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 3; i++) begin
            cyc();
            pulse_tick();
        end
        pulse_hit();
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        checks++;
        if (bus.state !== 3'd6) begin
            errors++;
            $display("FAIL illegal_inject: got st=%0d want 6", bus.state);
        end
        cyc();
        checks++;
        if ({bus.state, bus.sw_rst, bus.sw_pause, bus.play_en, bus.cd_val, bus.score_hi, bus.score_lo, bus.round_done}
            !== {3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL illegal_recover: got st=%0d rst=%b pau=%b en=%b cd=%0d score=%h%h done=%b want st=0 rst=1 pau=1 en=0 cd=0 score=00 done=0",
                     bus.state, bus.sw_rst, bus.sw_pause, bus.play_en, bus.cd_val, bus.score_hi, bus.score_lo, bus.round_done);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.tick_1hz = 1'b0;
        bus.btn_start = 1'b0;
        bus.btn_pause = 1'b0;
        bus.hit = 1'b0;
        bus.sw_small = 4'd0;
        bus.sw_big = 3'd0;
        test_reset();
        test_start();
        test_pause_abandon();
        test_round_end();
        test_score_sat();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
